sine_dds_sched: RTL and testbench

Two-channel DDS scheduler that time-shares one 256 x 8 synchronous sine ROM between two independent phase accumulators. On each sample tick it reads the ROM twice, first for channel 0 and then for channel 1, and presents one 8-bit sample per channel with a one-cycle valid strobe. It sits between the sample-rate timebase and the sine ROM, and feeds the downstream PWM/DAC channels.

---
 rtl/sine_pkg.sv | 26 ++
 rtl/phase_acc.sv | 33 +++
 rtl/sine_dds_sched.sv | 124 ++++++++++++
 tb/tb_sine_dds_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// rtl/sine_pkg.sv - shared constants and state type for the two-channel sine DDS scheduler
//
// Purpose: widths, ROM geometry and the scheduler state encoding shared by
// sine_dds_sched and phase_acc.
// Ports: none (package).

package sine_pkg;

  localparam int ROM_DEPTH = 256;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int PHASE_W   = 16;

  // ROM[0] of the sine table; also the output level of a zero-phase channel.
  localparam logic [DATA_W-1:0] MIDSCALE = 8'd128;

  // IDLE waits for a tick; ADDR0/ADDR1 issue the two ROM reads; CAP1 takes
  // the second sample and advances both accumulators.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR0 = 2'd1,
    ADDR1 = 2'd2,
    CAP1  = 2'd3
  } state_t;

endpackage

// File: rtl/phase_acc.sv
// rtl/phase_acc.sv - modulo-2^W phase accumulator with synchronous clear and update enable
//
// Purpose: holds one DDS channel's phase and adds its frequency-control word
// when told to.
// Ports:
//   Clk  in   clock, rising edge
//   clr  in   synchronous clear (dominates upd)
//   upd  in   add fcw to the accumulator this edge
//   fcw  in   frequency-control word, sampled only on an update edge
//   acc  out  current phase

module phase_acc
  import sine_pkg::*;
#(
  parameter int W = PHASE_W
) (
  input  logic         Clk,
  input  logic         clr,
  input  logic         upd,
  input  logic [W-1:0] fcw,
  output logic [W-1:0] acc
);

  // Natural W-bit overflow gives the wrap modulo 2^W.
  always_ff @(posedge Clk) begin
    if (clr) begin
      acc <= '0;
    end else if (upd) begin
      acc <= acc + fcw;
    end
  end

endmodule

// File: rtl/sine_dds_sched.sv
// rtl/sine_dds_sched.sv - two-channel DDS scheduler time-sharing one synchronous sine ROM
//
// Purpose: on each accepted tick, reads the external ROM for channel 0 then
// channel 1, latches both samples with one-cycle valid strobes, then advances
// both phase accumulators.
// Ports:
//   Clk        in   sole clock, rising edge
//   Rst        in   synchronous active-high reset
//   en         in   allows a tick in IDLE to start a sequence
//   tick       in   one-cycle sample request
//   fcw0/fcw1  in   per-channel frequency-control words
//   rom_addr   out  registered ROM address (top ADDR_W bits of the phase)
//   rom_en     out  registered ROM read enable
//   rom_data   in   ROM output, one cycle after rom_addr/rom_en
//   data0/1    out  held channel samples
//   valid0/1   out  one-cycle strobe when the matching sample updates
//   busy       out  a read sequence is in progress
//   overrun    out  sticky: a tick arrived while busy (cleared only by Rst)

module sine_dds_sched
  import sine_pkg::*;
#(
  parameter int PHASE_W_P = PHASE_W,
  parameter int ADDR_W_P  = ADDR_W,
  parameter int DATA_W_P  = DATA_W
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 en,
  input  logic                 tick,
  input  logic [PHASE_W_P-1:0] fcw0,
  input  logic [PHASE_W_P-1:0] fcw1,
  output logic [ADDR_W_P-1:0]  rom_addr,
  output logic                 rom_en,
  input  logic [DATA_W_P-1:0]  rom_data,
  output logic [DATA_W_P-1:0]  data0,
  output logic [DATA_W_P-1:0]  data1,
  output logic                 valid0,
  output logic                 valid1,
  output logic                 busy,
  output logic                 overrun
);

  state_t               state;
  logic [PHASE_W_P-1:0] acc0;
  logic [PHASE_W_P-1:0] acc1;
  logic                 acc_upd;

  // Accumulators advance on the edge that leaves CAP1, so a new fcw only
  // takes effect for the following sequence.
  assign acc_upd = (state == CAP1);

  phase_acc #(.W(PHASE_W_P)) u_acc0 (
    .Clk (Clk),
    .clr (Rst),
    .upd (acc_upd),
    .fcw (fcw0),
    .acc (acc0)
  );

  phase_acc #(.W(PHASE_W_P)) u_acc1 (
    .Clk (Clk),
    .clr (Rst),
    .upd (acc_upd),
    .fcw (fcw1),
    .acc (acc1)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      rom_en   <= 1'b0;
      data0    <= '0;
      data1    <= '0;
      valid0   <= 1'b0;
      valid1   <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      valid0 <= 1'b0;
      valid1 <= 1'b0;

      // Ticks outside IDLE are dropped, but remembered as an overrun
      // regardless of en.
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick && en) begin
            state    <= ADDR0;
            rom_addr <= acc0[PHASE_W_P-1 -: ADDR_W_P];
            rom_en   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ADDR0: begin
          // Channel 0 read is in flight inside the ROM; queue channel 1.
          state    <= ADDR1;
          rom_addr <= acc1[PHASE_W_P-1 -: ADDR_W_P];
          rom_en   <= 1'b1;
        end
        ADDR1: begin
          state  <= CAP1;
          data0  <= rom_data;
          valid0 <= 1'b1;
          rom_en <= 1'b0;
        end
        CAP1: begin
          state  <= IDLE;
          data1  <= rom_data;
          valid1 <= 1'b1;
          busy   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sine_dds_sched.sv
// tb/tb_sine_dds_sched.sv - scoreboard bench for sine_dds_sched with a behavioural sine ROM

module tb_sine_dds_sched;
  import sine_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        en = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] fcw0 = '0;
  logic [15:0] fcw1 = '0;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [7:0]  rom_data = '0;
  logic [7:0]  data0;
  logic [7:0]  data1;
  logic        valid0;
  logic        valid1;
  logic        busy;
  logic        overrun;

  sine_dds_sched dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .en       (en),
    .tick     (tick),
    .fcw0     (fcw0),
    .fcw1     (fcw1),
    .rom_addr (rom_addr),
    .rom_en   (rom_en),
    .rom_data (rom_data),
    .data0    (data0),
    .data1    (data1),
    .valid0   (valid0),
    .valid1   (valid1),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Sine table: 128 + 127*sin(2*pi*i/256), rounded.
  logic [7:0] rom [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * i / 256.0) + 0.5));
    end
  end

  always @(posedge Clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  typedef struct {
    int         t;
    logic [7:0] d;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] m_acc0 = '0;
  logic [15:0] m_acc1 = '0;
  int          last_acc = -100;
  int          ov_cyc = 1 << 30;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_acc0   = '0;
    m_acc1   = '0;
    last_acc = -100;
    ov_cyc   = 1 << 30;
  endtask

  // Drives a one-cycle tick in the current cycle and records what the block
  // should do with it.
  task automatic send_tick();
    tick = 1'b1;
    if (en && (cyc >= last_acc + 4)) begin
      q0.push_back('{cyc + 3, rom[m_acc0[15:8]]});
      q1.push_back('{cyc + 4, rom[m_acc1[15:8]]});
      m_acc0   = m_acc0 + fcw0;
      m_acc1   = m_acc1 + fcw1;
      last_acc = cyc;
    end else if ((cyc < last_acc + 4) && (ov_cyc > cyc)) begin
      ov_cyc = cyc;
    end
    step();
    tick = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rom_addr"}, rom_addr, 0);
    check({pfx, "_rom_en"}, rom_en, 0);
    check({pfx, "_data0"}, data0, 0);
    check({pfx, "_data1"}, data1, 0);
    check({pfx, "_valid0"}, valid0, 0);
    check({pfx, "_valid1"}, valid1, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_overrun"}, overrun, 0);
  endtask

  exp_t e0;
  exp_t e1;
  always @(negedge Clk) begin
    if (!Rst) begin
      if (valid0) begin
        if (q0.size() == 0) begin
          check("valid0_extra", valid0, 0);
        end else begin
          e0 = q0.pop_front();
          check("valid0_cycle", cyc, e0.t);
          check("data0", data0, e0.d);
        end
      end else if ((q0.size() > 0) && (cyc >= q0[0].t)) begin
        check("valid0_missing", valid0, 1);
        void'(q0.pop_front());
      end
      if (valid1) begin
        if (q1.size() == 0) begin
          check("valid1_extra", valid1, 0);
        end else begin
          e1 = q1.pop_front();
          check("valid1_cycle", cyc, e1.t);
          check("data1", data1, e1.d);
        end
      end else if ((q1.size() > 0) && (cyc >= q1[0].t)) begin
        check("valid1_missing", valid1, 1);
        void'(q1.pop_front());
      end
      if (valid0 && valid1) check("valid_exclusive", valid1, 0);
      check("busy", busy, (cyc > last_acc) && (cyc <= last_acc + 3));
      check("overrun", overrun, cyc > ov_cyc);
    end
  end

  initial begin
    // Reset held for 3 cycles.
    Rst = 1'b1;
    idle(3);
    check_all_zero("rst");
    Rst = 1'b0;
    model_reset();
    idle(2);

    // Frequency: ticks every 10 cycles.
    en   = 1'b1;
    fcw0 = 16'h0100;
    fcw1 = 16'h4000;
    for (int i = 0; i < 5; i++) begin
      send_tick();
      idle(9);
      if (i == 0) begin
        check("first_data0", data0, MIDSCALE);
        check("first_data1", data1, rom[0]);
      end
      if (i == 1) begin
        check("second_data0", data0, rom[1]);
        check("second_data1", data1, rom[64]);
      end
      if (i == 4) check("fifth_data1_wrap", data1, rom[0]);
    end

    // Back-to-back at minimum spacing of 4.
    fcw0 = 16'h0b37;
    fcw1 = 16'h1d05;
    for (int i = 0; i < 6; i++) begin
      send_tick();
      idle(3);
    end
    idle(4);
    check("b2b_overrun", overrun, 0);

    // en dropped the cycle after the tick; then ticks with en low.
    send_tick();
    en = 1'b0;
    idle(5);
    for (int i = 0; i < 3; i++) begin
      send_tick();
      idle(4);
    end
    check("en_low_overrun", overrun, 0);
    check("en_low_busy", busy, 0);
    en = 1'b1;

    // Zero fcw holds the phase.
    fcw0 = 16'h0000;
    fcw1 = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      send_tick();
      idle(5);
    end

    // Overrun: second tick two cycles after the first is dropped.
    fcw0 = 16'h1234;
    fcw1 = 16'h0777;
    send_tick();
    idle(1);
    send_tick();
    idle(6);
    check("overrun_set", overrun, 1);
    send_tick();
    idle(6);
    check("overrun_sticky", overrun, 1);

    // Reset mid-sequence at T+2.
    send_tick();
    step();
    Rst = 1'b1;
    model_reset();
    step();
    check_all_zero("mrst");
    Rst = 1'b0;
    idle(2);
    send_tick();
    idle(5);
    check("mrst_data0", data0, rom[0]);
    check("mrst_data1", data1, rom[0]);

    idle(4);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
